// File: rtl/lc3_fetch_unit.sv
// LC-3 fetch stage: owns the PC, issues instruction reads with a ready
// handshake, and resolves BR, JMP/RET and JSR/JSRR redirects with an R7 link.
module lc3_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int OFF_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              mem_ready,
  input  logic              pc_update,
  input  logic [3:0]        opCode_in,
  input  logic [OFF_W-1:0]  offset_in,
  input  logic              jsr_imm,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rd_en,
  output logic              wea_out,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              taken,
  output logic [ADDR_W-1:0] link_out,
  output logic              link_we,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_link;
  logic              r_rd_en;
  logic              r_ir_valid;
  logic              r_taken;
  logic              r_link_we;
  logic              r_busy;

  logic [ADDR_W-1:0] w_next_pc;
  logic              w_taken;
  logic              w_link;
  logic              w_br_hit;
  logic              w_unused_ok;

  // Sign-extend the 9-bit BR offset to the PC width.
  function automatic logic [ADDR_W-1:0] f_sext9(input logic [8:0] v);
    f_sext9 = {{(ADDR_W-9){v[8]}}, v};
  endfunction

  // Sign-extend the 11-bit JSR offset to the PC width.
  function automatic logic [ADDR_W-1:0] f_sext11(input logic [10:0] v);
    f_sext11 = {{(ADDR_W-11){v[10]}}, v};
  endfunction

  // Offset bits above bit 10 exist only for wider instruction formats.
  assign w_unused_ok = &{1'b0, offset_in};

  // Decode the executed instruction into the resolved PC and redirect flags.
  always_comb begin
    w_next_pc = r_pc;
    w_taken   = 1'b0;
    w_link    = 1'b0;
    w_br_hit  = (br_nzp & result_nzp) != 3'b000;
    case (opCode_in)
      4'b0000: begin
        if (w_br_hit) begin
          w_next_pc = r_pc + f_sext9(offset_in[8:0]);
          w_taken   = 1'b1;
        end else begin
          w_next_pc = r_pc;
          w_taken   = 1'b0;
        end
      end
      4'b1100: begin
        w_next_pc = reg_in;
        w_taken   = 1'b1;
      end
      4'b0100: begin
        w_link  = 1'b1;
        w_taken = 1'b1;
        if (jsr_imm) begin
          w_next_pc = r_pc + f_sext11(offset_in[10:0]);
        end else begin
          w_next_pc = reg_in;
        end
      end
      default: begin
        w_next_pc = r_pc;
        w_taken   = 1'b0;
      end
    endcase
  end

  // Fetch FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_link     <= {ADDR_W{1'b0}};
      r_rd_en    <= 1'b0;
      r_ir_valid <= 1'b0;
      r_taken    <= 1'b0;
      r_link_we  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      r_taken    <= 1'b0;
      r_link_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fetch_start) begin
            r_state <= ST_FETCH;
            r_addr  <= r_pc;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            r_state    <= ST_EXEC;
            r_pc       <= r_pc + PC_ONE;
            r_ir_valid <= 1'b1;
            r_rd_en    <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (pc_update) begin
            r_pc      <= w_next_pc;
            r_taken   <= w_taken;
            r_link_we <= w_link;
            if (w_link) begin
              r_link <= r_pc;
            end
            if (fetch_start) begin
              r_state <= ST_FETCH;
              r_addr  <= w_next_pc;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out = r_addr;
  assign rd_en    = r_rd_en;
  assign wea_out  = 1'b0;
  assign pc       = r_pc;
  assign ir_valid = r_ir_valid;
  assign taken    = r_taken;
  assign link_out = r_link;
  assign link_we  = r_link_we;
  assign busy     = r_busy;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: expected results are queued as
// stimulus is driven and compared when the DUT produces its output.
module tb_lc3_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start, mem_ready, pc_update, jsr_imm;
  logic [3:0]  opCode_in;
  logic [10:0] offset_in;
  logic [15:0] reg_in;
  logic [2:0]  br_nzp, result_nzp;
  logic [15:0] addr_out, pc, link_out;
  logic        rd_en, wea_out, ir_valid, taken, link_we, busy;

  typedef struct {
    logic [15:0] pc;
    logic        taken;
    logic        link_we;
    logic [15:0] link;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  lc3_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .mem_ready(mem_ready),
    .pc_update(pc_update), .opCode_in(opCode_in), .offset_in(offset_in),
    .jsr_imm(jsr_imm), .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp),
    .addr_out(addr_out), .rd_en(rd_en), .wea_out(wea_out), .pc(pc),
    .ir_valid(ir_valid), .taken(taken), .link_out(link_out), .link_we(link_we),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one expected record and compare it with the DUT outputs.
  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"}, {16'd0, pc}, {16'd0, e.pc});
      chk({tag, "_taken"}, {31'd0, taken}, {31'd0, e.taken});
      chk({tag, "_link_we"}, {31'd0, link_we}, {31'd0, e.link_we});
      if (e.link_we) chk({tag, "_link"}, {16'd0, link_out}, {16'd0, e.link});
    end
  endtask

  // One fetch at exp_addr with 'waits' stalled cycles; pc must become exp_pc.
  task automatic do_fetch(input string tag, input int waits,
                          input logic [15:0] exp_addr, input logic [15:0] exp_pc);
    exp_t e;
    e.pc = exp_pc; e.taken = 1'b0; e.link_we = 1'b0; e.link = 16'h0000;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    mem_ready   = 1'b0;
    sb_q.push_back(e);
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_rd_en_wait"}, {31'd0, rd_en}, 32'd1);
      chk({tag, "_addr_wait"}, {16'd0, addr_out}, {16'd0, exp_addr});
      tick();
    end
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd1);
    chk({tag, "_addr"}, {16'd0, addr_out}, {16'd0, exp_addr});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 8 && !ir_valid; i++) tick();
    chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd1);
    chk({tag, "_rd_en_off"}, {31'd0, rd_en}, 32'd0);
    sb_check(tag);
    tick();
    chk({tag, "_ir_pulse"}, {31'd0, ir_valid}, 32'd0);
  endtask

  // Present a pc_update with the given instruction fields and expected result.
  task automatic do_update(input string tag, input logic [3:0] op, input logic [10:0] off,
                           input logic jimm, input logic [15:0] rv, input logic [2:0] bn,
                           input logic [2:0] rn, input logic fs, input logic [15:0] exp_pc,
                           input logic exp_taken, input logic exp_lwe,
                           input logic [15:0] exp_link);
    exp_t e;
    e.pc = exp_pc; e.taken = exp_taken; e.link_we = exp_lwe; e.link = exp_link;
    opCode_in = op; offset_in = off; jsr_imm = jimm; reg_in = rv;
    br_nzp = bn; result_nzp = rn; fetch_start = fs; pc_update = 1'b1;
    sb_q.push_back(e);
    tick();
    pc_update = 1'b0;
    fetch_start = 1'b0;
    sb_check(tag);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, fs});
    chk({tag, "_rd_en"}, {31'd0, rd_en}, {31'd0, fs});
    if (fs) chk({tag, "_b2b_addr"}, {16'd0, addr_out}, {16'd0, exp_pc});
    tick();
    chk({tag, "_taken_pulse"}, {31'd0, taken}, 32'd0);
    chk({tag, "_link_we_pulse"}, {31'd0, link_we}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_start = 1'b0; mem_ready = 1'b0; pc_update = 1'b0; jsr_imm = 1'b0;
    opCode_in = 4'd0; offset_in = 11'd0; reg_in = 16'd0; br_nzp = 3'd0; result_nzp = 3'd0;
    repeat (5) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_link", {16'd0, link_out}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_addr", {16'd0, addr_out}, 32'd0);
      chk("idle_pc", {16'd0, pc}, 32'd0);
      chk("idle_wea", {31'd0, wea_out}, 32'd0);
      chk("idle_rd_en", {31'd0, rd_en}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    do_fetch("wait3", 3, 16'h0000, 16'h0001);
    // fetch_start alone in EXEC must not leave EXEC.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("exec_fs_busy", {31'd0, busy}, 32'd1);
    chk("exec_fs_rd_en", {31'd0, rd_en}, 32'd0);
    do_update("jmp3000", 4'b1100, 11'd0, 1'b0, 16'h3000, 3'b000, 3'b000, 1'b0,
              16'h3000, 1'b1, 1'b0, 16'h0000);
    do_fetch("f3000", 0, 16'h3000, 16'h3001);
    do_update("brz_taken", 4'b0000, 11'h1FE, 1'b0, 16'h0000, 3'b010, 3'b010, 1'b0,
              16'h2FFF, 1'b1, 1'b0, 16'h0000);
    do_fetch("f2fff", 1, 16'h2FFF, 16'h3000);
    do_update("br_000", 4'b0000, 11'h1FE, 1'b0, 16'h0000, 3'b000, 3'b111, 1'b0,
              16'h3000, 1'b0, 1'b0, 16'h0000);
    do_fetch("f3000b", 0, 16'h3000, 16'h3001);
    do_update("brz_not", 4'b0000, 11'h1FE, 1'b0, 16'h0000, 3'b010, 3'b100, 1'b0,
              16'h3001, 1'b0, 1'b0, 16'h0000);
    do_fetch("f3001", 0, 16'h3001, 16'h3002);
    do_update("jmp3004", 4'b1100, 11'd0, 1'b0, 16'h3004, 3'b000, 3'b000, 1'b0,
              16'h3004, 1'b1, 1'b0, 16'h0000);
    do_fetch("f3004", 2, 16'h3004, 16'h3005);
    do_update("jsr", 4'b0100, 11'h010, 1'b1, 16'h0000, 3'b000, 3'b000, 1'b0,
              16'h3015, 1'b1, 1'b1, 16'h3005);
    do_fetch("f3015", 0, 16'h3015, 16'h3016);
    do_update("jsrr", 4'b0100, 11'h010, 1'b0, 16'h4000, 3'b000, 3'b000, 1'b0,
              16'h4000, 1'b1, 1'b1, 16'h3016);
    chk("jsrr_link_hold", {16'd0, link_out}, 32'h3016);
    do_fetch("f4000", 0, 16'h4000, 16'h4001);
    do_update("jmpffff", 4'b1100, 11'd0, 1'b0, 16'hFFFF, 3'b000, 3'b000, 1'b0,
              16'hFFFF, 1'b1, 1'b0, 16'h0000);
    do_fetch("wrap", 0, 16'hFFFF, 16'h0000);
    do_update("b2b", 4'b0001, 11'h7FF, 1'b1, 16'h1234, 3'b111, 3'b111, 1'b1,
              16'h0000, 1'b0, 1'b0, 16'h0000);

    // Still in FETCH with mem_ready low: reset must act between edges.
    chk("midfetch_rd_en", {31'd0, rd_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pc", {16'd0, pc}, 32'd0);
    chk("arst_addr", {16'd0, addr_out}, 32'd0);
    chk("arst_flags", {28'd0, ir_valid, taken, link_we, wea_out}, 32'd0);
    chk("arst_link", {16'd0, link_out}, 32'd0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("post_rst_pc", {16'd0, pc}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
- Parametrised next-generation LC-3 fetch stage: owns the PC, issues instruction-fetch reads to memory with a ready handshake, and applies PC redirects for BR, JMP/RET and JSR/JSRR.
- Generalises the earlier fetch block in address width, reset vector and offset width.
- Adds a memory wait handshake, a JSR link output (R7 write) and back-to-back fetch.
- Sits between the control FSM (issues fetch_start and pc_update), the register file (reg_in, link) and instruction memory.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.
- OFF_W, 11, width of offset_in; must be at least 11.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_start  in  1  request one instruction fetch at the current PC.
- mem_ready  in  1  memory has returned the read data for addr_out this cycle.
- pc_update  in  1  control strobe to resolve the PC for the executed instruction.
- opCode_in  in  4  opcode of the executed instruction.
- offset_in  in  OFF_W  instruction immediate bits [OFF_W-1:0].
- jsr_imm  in  1  instruction bit 11: 1 selects JSR, 0 selects JSRR.
- reg_in  in  ADDR_W  BaseR value for JMP/JSRR.
- br_nzp  in  3  nzp field of a BR instruction.
- result_nzp  in  3  current condition codes.
- addr_out  out  ADDR_W  memory address.
- rd_en  out  1  memory read request.
- wea_out  out  1  memory write enable; always 0 from this block.
- pc  out  ADDR_W  architectural PC.
- ir_valid  out  1  one-cycle pulse: instruction data is valid on the memory bus.
- taken  out  1  one-cycle pulse: redirect applied.
- link_out  out  ADDR_W  return address for R7.
- link_we  out  1  one-cycle pulse: write link_out to R7.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (async, any state, including mid-fetch):
  - State goes to IDLE.
  - pc=RESET_PC, addr_out=RESET_PC.
  - rd_en=0, wea_out=0, ir_valid=0, taken=0, link_we=0, link_out=0, busy=0.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W and wraps silently. sext9 and sext11 mean sign-extension of offset_in[8:0] and offset_in[10:0] to ADDR_W.
- IDLE:
  - rd_en=0; addr_out and pc hold.
  - fetch_start=1 moves to FETCH next cycle.
  - pc_update in IDLE is ignored.
- FETCH:
  - addr_out=pc, rd_en=1. Stays in FETCH indefinitely while mem_ready=0.
  - On a clock edge with mem_ready=1: ir_valid=1 for the next cycle, pc<=pc+1, go to EXEC.
  - Minimum latency from fetch_start to ir_valid is 2 cycles.
  - fetch_start during FETCH is ignored (not queued).
- EXEC:
  - rd_en=0. Waits for pc_update. Here pc already holds the incremented value (PC+1).
  - On pc_update, decode opCode_in:
    - 0000 BR: if (br_nzp & result_nzp)!=0, then pc<=pc+sext9 and taken=1; otherwise pc holds. br_nzp=000 is never taken.
    - 1100 JMP/RET: pc<=reg_in, taken=1.
    - 0100 JSR/JSRR: link_out<=pc (pre-update value), link_we=1. If jsr_imm=1, pc<=pc+sext11; else pc<=reg_in. taken=1.
    - All other opcodes: pc holds, taken=0.
  - After pc_update: if fetch_start is also 1 in the same cycle, go directly to FETCH (addr_out takes the new pc); otherwise go to IDLE.
  - fetch_start without pc_update in EXEC is ignored.
- Output pulses: taken, link_we and ir_valid are registered and high for exactly one cycle.
- busy=1 in FETCH and EXEC.

Test Plan:
- No start: hold rst=1 for 5 cycles, release, keep fetch_start=0 for 10 cycles -> addr_out=0, pc=0, wea_out=0, rd_en=0, busy=0 throughout.
- Wait-state fetch: fetch_start pulse at pc=0x0000, mem_ready held low for 3 cycles then high -> rd_en=1 and addr_out=0x0000 for 4 cycles, ir_valid pulses once, pc=0x0001.
- BRz: result_nzp=010, br_nzp=010, offset_in[8:0]=0x1FE (-2), pc=0x3001, then pc_update -> pc=0x2FFF, taken=1 for one cycle. Repeat with result_nzp=100 -> pc=0x3001, taken=0.
- JSR/JSRR:
  - pc=0x3005, jsr_imm=1, offset_in=0x010, pc_update -> link_out=0x3005, link_we pulse, pc=0x3015.
  - jsr_imm=0, reg_in=0x4000 -> pc=0x4000.
- Wrap and back-to-back: pc=0xFFFF, fetch with mem_ready=1 -> pc=0x0000. Then pc_update with opcode 0001 and fetch_start=1 together -> FETCH entered the next cycle with addr_out=0x0000.
- Mid-fetch reset: assert rst while in FETCH with mem_ready=0 -> all outputs at reset values immediately, asynchronously before the next edge. After release, state is IDLE.
